// File: rtl/gain_multiplier_seq.sv
// Sequential signed-by-unsigned shift-add gain multiplier with fixed-point
// output scaling, saturation and a start/busy/done handshake.
module gain_multiplier_seq #(
  parameter int DATA_W = 6,
  parameter int GAIN_W = 6,
  parameter int OUT_W  = 6,
  parameter int FRAC_W = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              start,
  input  logic [DATA_W-1:0] e,
  input  logic [GAIN_W-1:0] k,
  output logic              busy,
  output logic              done,
  output logic [OUT_W-1:0]  product,
  output logic              sat
);

  localparam int FW    = DATA_W + GAIN_W;
  localparam int CNT_W = (GAIN_W > 1) ? $clog2(GAIN_W) : 1;

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t              r_state, w_next;
  logic [FW-1:0]       r_mcand, r_acc;
  logic [GAIN_W-1:0]   r_mplier;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_done, r_sat;
  logic [OUT_W-1:0]    r_product;

  logic                w_accept, w_last, w_ovf;
  logic signed [FW-1:0] w_sum, w_t;
  logic [FW-OUT_W:0]   w_hi;
  logic [OUT_W-1:0]    w_prod_sat;

  assign w_accept = (r_state == S_IDLE) && start;
  assign w_last   = (r_state == S_RUN) && (r_cnt == CNT_W'(GAIN_W - 1));

  // Final sum includes the current step's partial product; t fits OUT_W only
  // when every bit above the result sign equals that sign.
  always_comb begin
    w_sum      = r_acc + (r_mplier[0] ? r_mcand : '0);
    w_t        = w_sum >>> FRAC_W;
    w_hi       = w_t[FW-1:OUT_W-1];
    w_ovf      = ~((&w_hi) | ~(|w_hi));
    w_prod_sat = w_t[OUT_W-1:0];
    if (w_ovf)
      w_prod_sat = w_t[FW-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   r_state <= S_IDLE;
    else if (ena) r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start)  w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = (r_state == S_RUN);
    done    = r_done;
    product = r_product;
    sat     = r_sat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand   <= '0;
      r_acc     <= '0;
      r_mplier  <= '0;
      r_cnt     <= '0;
      r_done    <= 1'b0;
      r_sat     <= 1'b0;
      r_product <= '0;
    end else if (ena) begin
      r_done <= w_last;
      if (w_accept) begin
        r_mcand  <= {{GAIN_W{e[DATA_W-1]}}, e};
        r_mplier <= k;
        r_acc    <= '0;
        r_cnt    <= '0;
      end else if (r_state == S_RUN) begin
        r_acc    <= w_sum;
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt + 1'b1;
        if (w_last) begin
          r_product <= w_prod_sat;
          r_sat     <= w_ovf;
        end
      end
    end
  end

endmodule
